// File: rtl/wtm_pkg.sv
// Shared constants, the pipeline stage record and tree-sizing helpers for the Wallace multiplier.
package wtm_pkg;

    localparam int WTM_LATENCY = 3;
    localparam int ACC_GUARD   = 8;
    localparam int MAX_WIDTH   = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic                 sgn;
        logic                 clr;
        logic                 valid;
    } stage_t;

    // Each 3:2 layer turns every full group of three rows into two; leftovers pass on.
    function automatic int next_rows(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int tree_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = next_rows(r);
            l++;
        end
        return l;
    endfunction

    function automatic int rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int k = 0; k < lvl; k++) r = next_rows(r);
        return r;
    endfunction

endpackage

// File: rtl/wallace_reduce.sv
// Combinational partial-product array (Baugh-Wooley when sgn=1) reduced to sum/carry rows.
module wallace_reduce
    import wtm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic [2*WIDTH-1:0] sum_r,
    output logic [2*WIDTH-1:0] carry_r
);
    localparam int OUT_W  = 2 * WIDTH;
    localparam int NROWS  = WIDTH + 1;
    localparam int LEVELS = tree_levels(NROWS);

    logic [OUT_W-1:0] pp [NROWS];

    // Row WIDTH carries the two Baugh-Wooley correction constants.
    always_comb begin
        for (int i = 0; i < NROWS; i++) pp[i] = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (a[j] & b[i]) ^ (sgn & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
        if (sgn) begin
            pp[WIDTH][WIDTH]   = 1'b1;
            pp[WIDTH][OUT_W-1] = 1'b1;
        end
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int RN = rows_at(NROWS, l);
        logic [OUT_W-1:0] row [RN];

        if (l == 0) begin : g_init
            for (genvar r = 0; r < RN; r++) begin : g_r
                assign row[r] = pp[r];
            end
        end else begin : g_red
            localparam int PN = rows_at(NROWS, l-1);
            localparam int G  = PN / 3;

            for (genvar k = 0; k < G; k++) begin : g_csa
                logic [OUT_W-1:0] x, y, z, s;
                logic [OUT_W-2:0] c;
                assign x = g_lvl[l-1].row[3*k];
                assign y = g_lvl[l-1].row[3*k+1];
                assign z = g_lvl[l-1].row[3*k+2];
                for (genvar bt = 0; bt < OUT_W-1; bt++) begin : g_bit
                    fa u_fa (.a(x[bt]), .b(y[bt]), .ci(z[bt]), .s(s[bt]), .co(c[bt]));
                end
                // Carry out of the top column falls outside the product width.
                assign s[OUT_W-1] = x[OUT_W-1] ^ y[OUT_W-1] ^ z[OUT_W-1];
                assign row[2*k]   = s;
                assign row[2*k+1] = {c, 1'b0};
            end

            if (PN % 3 == 2) begin : g_pair
                logic [OUT_W-1:0] x, y, s;
                logic [OUT_W-2:0] c;
                assign x = g_lvl[l-1].row[3*G];
                assign y = g_lvl[l-1].row[3*G+1];
                for (genvar bt = 0; bt < OUT_W-1; bt++) begin : g_bit
                    ha u_ha (.a(x[bt]), .b(y[bt]), .s(s[bt]), .co(c[bt]));
                end
                assign s[OUT_W-1]   = x[OUT_W-1] ^ y[OUT_W-1];
                assign row[2*G]     = s;
                assign row[2*G+1]   = {c, 1'b0};
            end else if (PN % 3 == 1) begin : g_pass
                assign row[2*G] = g_lvl[l-1].row[3*G];
            end
        end
    end

    assign sum_r   = g_lvl[LEVELS].row[0];
    assign carry_r = g_lvl[LEVELS].row[1];

endmodule

// File: rtl/wtm_cells.sv
// Full-adder and half-adder cells used by the reduction tree.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

// File: rtl/pipelined_wallace_multiplier.sv
// WIDTH x WIDTH signed/unsigned multiplier; optional accumulator under WTM_ACCUMULATE_EN.
// Latency 3 cycles (capture, Wallace reduce, final add), 1 result per cycle.
// Backpressure: global stall, in_ready = !out_valid | out_ready; all stages hold while stalled.
module pipelined_wallace_multiplier
    import wtm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OUT_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_p
`ifdef WTM_ACCUMULATE_EN
    ,
    input  logic                       acc_clr,
    output logic [OUT_W+ACC_GUARD-1:0] acc_out
`endif
);
    logic             advance;
    logic             clr_in;
    stage_t           s1;
    logic [OUT_W-1:0] sum_c, carry_c, sum_q, carry_q;
    logic             v2;
    logic             unused_stage_bits;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef WTM_ACCUMULATE_EN
    assign clr_in = acc_clr;
`else
    assign clr_in = 1'b0;
`endif

    wallace_reduce #(.WIDTH(WIDTH)) u_reduce (
        .a       (s1.a[WIDTH-1:0]),
        .b       (s1.b[WIDTH-1:0]),
        .sgn     (s1.sgn),
        .sum_r   (sum_c),
        .carry_r (carry_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            v2        <= 1'b0;
            sum_q     <= '0;
            carry_q   <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
        end else if (advance) begin
            s1.a      <= MAX_WIDTH'(in_a);
            s1.b      <= MAX_WIDTH'(in_b);
            s1.sgn    <= in_signed;
            s1.clr    <= clr_in;
            s1.valid  <= in_valid;
            v2        <= s1.valid;
            sum_q     <= sum_c;
            carry_q   <= carry_c;
            out_valid <= v2;
            // out_p keeps the last product across bubbles.
            if (v2) out_p <= sum_q + carry_q;
        end
    end

    assign unused_stage_bits = ^s1;

`ifdef WTM_ACCUMULATE_EN
    logic                       s2_sgn, s2_clr, out_sgn, out_clr;
    logic [OUT_W+ACC_GUARD-1:0] p_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sgn  <= 1'b0;
            s2_clr  <= 1'b0;
            out_sgn <= 1'b0;
            out_clr <= 1'b0;
        end else if (advance) begin
            s2_sgn <= s1.sgn;
            s2_clr <= s1.clr;
            if (v2) begin
                out_sgn <= s2_sgn;
                out_clr <= s2_clr;
            end
        end
    end

    assign p_ext = out_sgn ? {{ACC_GUARD{out_p[OUT_W-1]}}, out_p} : {{ACC_GUARD{1'b0}}, out_p};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= '0;
        end else if (out_valid && out_ready) begin
            acc_out <= (out_clr ? '0 : acc_out) + p_ext;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Directed and scoreboarded checks of the pipelined Wallace multiplier at WIDTH=8.
module tb_pipelined_wallace_multiplier;
    import wtm_pkg::*;

    localparam int W  = 8;
    localparam int OW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_signed;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready;
    logic [OW-1:0] out_p;
`ifdef WTM_ACCUMULATE_EN
    logic                    acc_clr;
    logic [OW+ACC_GUARD-1:0] acc_out;
`endif

    always #5 clk = ~clk;

    pipelined_wallace_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
`ifdef WTM_ACCUMULATE_EN
        ,
        .acc_clr   (acc_clr),
        .acc_out   (acc_out)
`endif
    );

    typedef struct {
        logic [OW-1:0] p;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    int            n_out  = 0;
    logic [OW-1:0] cur_exp;
    bit            lat_chk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int sa, sb, prod;
        sa   = s ? {{24{a[W-1]}}, a} : {24'b0, a};
        sb   = s ? {{24{b[W-1]}}, b} : {24'b0, b};
        prod = sa * sb;
        return prod[OW-1:0];
    endfunction

    // Called at a negedge with inputs set; scores the transfers due at the next posedge.
    task automatic tick();
        exp_t e;
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_p), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("product", 64'(out_p), 64'(e.p));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(WTM_LATENCY));
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{p: cur_exp, cyc: cyc, lat: lat_chk});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [OW-1:0] want);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        cur_exp   = want;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

`ifdef WTM_ACCUMULATE_EN
    task automatic acc_step(input logic [W-1:0] a, input logic [W-1:0] b, input logic clr,
                            input logic [OW+ACC_GUARD-1:0] want);
        acc_clr = clr;
        drive(a, b, 1'b0, OW'(a * b));
        acc_clr = 1'b0;
        drain(10);
        #1;
        check("acc_out", 64'(acc_out), 64'(want));
    endtask
`endif

    initial begin
        int base;
        logic [W-1:0] ra, rb;
        logic         rs;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;
        lat_chk   = 1'b1;
`ifdef WTM_ACCUMULATE_EN
        acc_clr   = 1'b0;
`endif
        @(negedge clk);
        tick();
        tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_p", 64'(out_p), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed corner products, hand-computed.
        drive(8'hFF, 8'hFF, 1'b0, 16'hFE01); drain(10);
        drive(8'h80, 8'h80, 1'b1, 16'h4000); drain(10);
        drive(8'hFF, 8'h02, 1'b1, 16'hFFFE); drain(10);
        drive(8'hFF, 8'h02, 1'b0, 16'h01FE); drain(10);
        drive(8'h7F, 8'h80, 1'b1, 16'hC080); drain(10);
        drive(8'h00, 8'hA5, 1'b1, 16'h0000); drain(10);

        // Back-to-back random stream.
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            ra        = W'($urandom);
            rb        = W'($urandom);
            rs        = 1'($urandom);
            in_valid  = 1'b1;
            in_a      = ra;
            in_b      = rb;
            in_signed = rs;
            cur_exp   = model(ra, rb, rs);
            tick();
        end
        in_valid = 1'b0;
        drain(10);
        check("stream_count", 64'(n_out - base), 64'd100);

        // Backpressure with three items in flight.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        drive(8'd10, 8'd20, 1'b0, 16'd200);
        drive(8'hFE, 8'h03, 1'b1, 16'hFFFA);
        drive(8'd7, 8'd9, 1'b0, 16'd63);
        in_valid = 1'b1;
        in_a     = 8'h55;
        in_b     = 8'h55;
        cur_exp  = 16'hBAD0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'(out_p), 64'd200);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_burst", 64'(out_valid), 64'd1);
            tick();
        end
        #1;
        check("bp_after", 64'(out_valid), 64'd0);
        check("bp_queue", 64'(exp_q.size()), 64'd0);
        lat_chk = 1'b1;

        // Reset with two items in flight.
        drive(8'd3, 8'd3, 1'b0, 16'd9);
        drive(8'd4, 8'd4, 1'b0, 16'd16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_p", 64'(out_p), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        base = n_out;
        repeat (6) tick();
        check("flush_no_stale", 64'(n_out - base), 64'd0);

`ifdef WTM_ACCUMULATE_EN
        acc_step(8'd3, 8'd4, 1'b0, 24'd12);
        acc_step(8'd5, 8'd6, 1'b0, 24'd42);
        acc_step(8'd2, 8'd2, 1'b1, 24'd4);
`endif

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/pipelined_wallace_multiplier.md
Name: pipelined_wallace_multiplier

Overview:
- Parametrised, pipelined successor to the existing fixed 8x8 combinational Wallace-tree multiplier.
- Computes WIDTH x WIDTH products, signed or unsigned, selected per transaction.
- Three register stages: operand capture, Wallace reduction to two rows, final carry-propagate add.
- Valid/ready handshake on both sides, so it drops into the datapath (filters, MAC units) with backpressure.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- OUT_W, 2*WIDTH, product width; derived, must not be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  product present.
- out_ready  in  1  consumer accepts.
- out_p  out  OUT_W  product.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: all stage valid bits 0, out_valid=0, out_p=0. in_ready=1 in the cycle after reset deasserts.
- Reset asserted mid-operation flushes all in-flight transactions; nothing is emitted after reset.
- Transfer rules:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
- Pipeline control: global stall. advance = !out_valid | out_ready. in_ready = advance, combinational from out_ready. All stages load only when advance=1.
- Stage S1: register in_a, in_b, in_signed, v1 = in_valid & in_ready.
- Stage S2:
  - Partial products use a Baugh-Wooley formulation when signed=1: invert the MSB-row and MSB-column partial products, and add constant 1 at bit WIDTH and at bit 2*WIDTH-1.
  - When signed=0, plain AND array.
  - Reduce with 3:2 full adders and 2:2 half adders to two OUT_W rows, sum_r and carry_r, then register them with v2.
- Stage S3: out_p = sum_r + carry_r, truncated to OUT_W bits (exact; no overflow possible). Register with out_valid.
- Latency: exactly 3 cycles from input transfer to out_valid when there is no stall.
- Throughput: 1 per cycle.
- Bubbles (v=0) propagate. Data registers of invalid stages may hold stale values, but out_p holds its last value while out_valid=0.
- Stall: while out_valid=1 and out_ready=0, out_p and all stage registers are held stable. in_ready=0.
- Simultaneous input transfer and output transfer in one cycle is legal. Pipeline shifts by one.
- Signed extremes:
  - -2^(W-1) * -2^(W-1) = 2^(2W-2), fits in OUT_W.
  - For unsigned, (2^W-1)^2 fits in OUT_W.

Optional Feature:
- Macro WTM_ACCUMULATE_EN.
- When defined:
  - Adds ports acc_clr (in, 1) and acc_out (out, OUT_W+8).
  - acc_clr is sampled with each input transfer and carried down the pipeline.
  - On each output transfer, acc_out <= (clr ? 0 : acc_out) + sign-extended out_p (zero-extended when unsigned), with wrap-around modulo 2^(OUT_W+8).
  - acc_out resets to 0.
- When undefined: no extra ports, no accumulator logic.

Decomposition:
- Package wtm_pkg:
  - WTM_LATENCY = 3.
  - ACC_GUARD = 8.
  - typedef of the stage record {a, b, signed, clr, valid}.
- Sub-module wallace_reduce (parameter WIDTH): purely combinational partial-product generation plus reduction tree, outputting sum_r/carry_r. It reuses the existing fa/ha cells.

Test Plan:
- WIDTH=8, unsigned, a=255, b=255, out_ready=1 -> out_p=65025 (0xFE01) exactly 3 cycles after input transfer.
- WIDTH=8, signed:
  - a=0x80, b=0x80 -> out_p=0x4000.
  - a=0xFF, b=0x02 -> out_p=0xFFFE.
- Back-to-back stream of 100 random pairs with random in_signed, out_ready=1 -> one result per cycle, in order, matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles with 3 items in flight -> in_ready=0, out_p stable, no loss or duplication. After release, the 3 results emerge on consecutive cycles.
- Reset asserted for 1 cycle with 2 items in flight -> out_valid=0 the next cycle, out_p=0, no stale results emitted afterwards.
- With WTM_ACCUMULATE_EN: products 3*4, 5*6, then clr with 2*2 -> acc_out = 12, 42, 4.
